rocc_cmd_queue: RTL and testbench
=================================

ROCC_CMD_QUEUE -- requirements
Module: rocc_cmd_queue

Interface
REQ-001 Parameters SHALL be: WIDTH, default 64, operand data width; DEPTH, default 4, queue entries (power of two, >= 2); OPCODE, default 7'b0001011 (custom-0), the opcode the accelerator accepts.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clock  in  1  single clock, all logic rising-edge
  reset  in  1  synchronous, active-high
  i_cmd_valid  in  1  core command valid
  o_cmd_ready  out  1  queue can accept a command
  i_cmd_bits_inst_opcode  in  7  opcode
  i_cmd_bits_inst_funct  in  7  funct7
  i_cmd_bits_rs1  in  WIDTH  rs1 data
  i_cmd_bits_inst_xs1  in  1  rs1 valid
  i_cmd_bits_rs2  in  WIDTH  rs2 data
  i_cmd_bits_inst_xs2  in  1  rs2 valid
  i_cmd_bits_inst_rd  in  5  destination register
  i_cmd_bits_inst_xd  in  1  response expected
  o_acc_valid  out  1  head command valid toward accelerator
  i_acc_ready  in  1  accelerator accepts head command
  o_acc_funct  out  7  head funct7
  o_acc_rs1  out  WIDTH  head rs1 (masked)
  o_acc_rs2  out  WIDTH  head rs2 (masked)
  o_acc_rd  out  5  head rd
  o_acc_xd  out  1  head xd
  i_acc_busy  in  1  accelerator busy
  o_busy  out  1  queue or accelerator busy
  o_count  out  $clog2(DEPTH)+1  occupied entries
  o_drop  out  1  one-cycle pulse: command discarded

Function
REQ-003 Enqueue handshake SHALL be i_cmd_valid && o_cmd_ready; dequeue handshake SHALL be o_acc_valid && i_acc_ready.
REQ-004 o_cmd_ready SHALL equal (count != DEPTH), a function of registered state only, with no combinational path from i_acc_ready.
REQ-005 An enqueued command with opcode == OPCODE SHALL be written to the tail entry; the command SHALL be visible on o_acc_* no earlier than the cycle after the enqueue (1-cycle minimum latency, no fall-through).
REQ-006 An enqueued command with opcode != OPCODE SHALL be consumed without storage; o_drop SHALL be 1 in the following cycle only; count SHALL be unchanged by it.
REQ-007 The stored rs1 SHALL be zero when xs1 = 0; the stored rs2 SHALL be zero when xs2 = 0.
REQ-008 o_acc_valid SHALL equal (count != 0); when count == 0, o_acc_funct/rs1/rs2/rd/xd SHALL all be zero.
REQ-009 o_acc_* SHALL present the oldest entry (FIFO order), stable while o_acc_valid && !i_acc_ready.
REQ-010 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0; count SHALL track occupancy 0..DEPTH.
REQ-011 A simultaneous valid enqueue and dequeue SHALL leave count unchanged and advance both pointers; this SHALL be legal for every count from 1 to DEPTH-1.
REQ-012 When count == DEPTH, enqueue SHALL be blocked even if a dequeue occurs in that cycle; ready SHALL rise the cycle after the dequeue.
REQ-013 When count == 0, i_acc_ready SHALL have no effect.
REQ-014 o_busy SHALL equal (count != 0) || i_acc_busy (combinational).
REQ-015 o_count SHALL equal registered count.

Reset
REQ-016 While reset = 1 at a clock edge: pointers, count and o_drop SHALL be cleared; consequently o_cmd_ready = 1, o_acc_valid = 0, o_acc_* = 0, o_count = 0 from the next cycle.
REQ-017 Reset asserted mid-operation SHALL discard all queued commands, and any enqueue in that same cycle SHALL be ignored; storage array contents SHALL NOT require reset.

Structure
REQ-018 Package rocc_pkg SHALL hold the stored-command struct typedef (funct, rs1, rs2, rd, xd) and the opcode constants CUSTOM0..CUSTOM3.
REQ-019 Storage and pointers SHALL be a sub-module rocc_sync_fifo (parameterised by width and depth); opcode filter, operand masking and output zeroing SHALL stay in rocc_cmd_queue.

Verification
REQ-020 Single command: opcode 0x0B, funct 1, rs1 = 5, rs2 = 7, rd = 3, xd = 1, i_acc_ready = 1 -> o_acc_valid high exactly one cycle after the enqueue with rs1 = 5, rs2 = 7, rd = 3; o_count 0->1->0.
REQ-021 Fill: 5 back-to-back commands, i_acc_ready = 0 -> 4 accepted, o_cmd_ready = 0, o_count = 4; then ready = 1 -> outputs in order, o_cmd_ready high the cycle after the first dequeue.
REQ-022 Drop: opcode 0x2B -> accepted, o_drop = 1 for one cycle, o_acc_valid stays 0, o_count = 0.
REQ-023 Masking: xs1 = 0, rs1 = 0xFFFF, xs2 = 1, rs2 = 9 -> o_acc_rs1 = 0, o_acc_rs2 = 9.
REQ-024 Wrap and simultaneity: 10 commands with continuous enqueue and dequeue at count = 2 -> count holds at 2, order preserved across pointer wrap.
REQ-025 Reset mid-run: count = 3, reset for one cycle -> o_count = 0, o_acc_valid = 0, o_busy = i_acc_busy the next cycle.

Source files
------------

// File: rtl/rocc_pkg.sv
// rocc_pkg -- shared types and constants for the RoCC command queue.
//   rocc_cmd_t : one stored command (funct, masked rs1/rs2, rd, xd).
//   CUSTOM0..3 : RISC-V custom opcode space.
// Operand fields are sized to ROCC_XLEN. Narrower WIDTH instances zero-extend
// on write, so the upper storage bits are constant and trim away.
package rocc_pkg;
  localparam int ROCC_XLEN = 64;

  localparam logic [6:0] CUSTOM0 = 7'b0001011;
  localparam logic [6:0] CUSTOM1 = 7'b0101011;
  localparam logic [6:0] CUSTOM2 = 7'b1011011;
  localparam logic [6:0] CUSTOM3 = 7'b1111011;

  typedef struct packed {
    logic [6:0]           funct;
    logic [ROCC_XLEN-1:0] rs1;
    logic [ROCC_XLEN-1:0] rs2;
    logic [4:0]           rd;
    logic                 xd;
  } rocc_cmd_t;
endpackage

// File: rtl/rocc_cmd_queue_if.sv
// rocc_cmd_queue_if -- storage-side bundle between the queue front end
// (master) and rocc_sync_fifo (slave).
//   push/wdata : write request; ignored by the FIFO while full
//   pop        : read request; ignored by the FIFO while empty
//   rdata      : head entry (raw storage, not zeroed)
//   count      : occupancy 0..DEPTH
//   full/empty : decoded from the registered count
interface rocc_cmd_queue_if #(
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push;
  logic [W-1:0]  wdata;
  logic          pop;
  logic [W-1:0]  rdata;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  modport master (output push, wdata, pop, input rdata, count, full, empty);
  modport slave  (input push, wdata, pop, output rdata, count, full, empty);
endinterface

// File: rtl/rocc_sync_fifo.sv
// rocc_sync_fifo -- synchronous FIFO, DEPTH entries of W bits.
//   clock : rising-edge clock
//   reset : synchronous active-high; clears pointers and count only
//   f     : rocc_cmd_queue_if slave port (push/pop/rdata/count/full/empty)
// Push and pop in the same cycle are legal whenever not full / not empty.
// The full check uses registered count, so a pop does not free a slot for a
// push in the same cycle.
module rocc_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input logic             clock,
  input logic             reset,
  rocc_cmd_queue_if.slave f
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push, w_pop;

  assign w_push = f.push && !f.full;
  assign w_pop  = f.pop && !f.empty;

  // DEPTH is a power of two, so pointer increments wrap DEPTH-1 -> 0 naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage is not reset; a push during reset is dropped.
  always_ff @(posedge clock) begin
    if (w_push && !reset) r_mem[r_wptr] <= f.wdata;
  end

  assign f.rdata = r_mem[r_rptr];
  assign f.count = r_count;
  assign f.full  = (r_count == CW'(DEPTH));
  assign f.empty = (r_count == '0);
endmodule

// File: rtl/rocc_cmd_queue.sv
// rocc_cmd_queue -- RoCC command queue between the core and an accelerator.
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   i_cmd_* / o_cmd_ready  : core command handshake and fields
//   o_acc_* / i_acc_ready  : head command toward the accelerator
//   i_acc_busy / o_busy    : busy = queue non-empty or accelerator busy
//   o_count                : registered occupancy
//   o_drop                 : one-cycle pulse after a non-matching opcode is consumed
// Matching commands are stored with masked operands. Non-matching commands
// are acknowledged and discarded. Head outputs read zero while empty.
module rocc_cmd_queue
  import rocc_pkg::*;
#(
  parameter int         WIDTH  = 64,
  parameter int         DEPTH  = 4,
  parameter logic [6:0] OPCODE = CUSTOM0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [6:0]               i_cmd_bits_inst_opcode,
  input  logic [6:0]               i_cmd_bits_inst_funct,
  input  logic [WIDTH-1:0]         i_cmd_bits_rs1,
  input  logic                     i_cmd_bits_inst_xs1,
  input  logic [WIDTH-1:0]         i_cmd_bits_rs2,
  input  logic                     i_cmd_bits_inst_xs2,
  input  logic [4:0]               i_cmd_bits_inst_rd,
  input  logic                     i_cmd_bits_inst_xd,
  output logic                     o_acc_valid,
  input  logic                     i_acc_ready,
  output logic [6:0]               o_acc_funct,
  output logic [WIDTH-1:0]         o_acc_rs1,
  output logic [WIDTH-1:0]         o_acc_rs2,
  output logic [4:0]               o_acc_rd,
  output logic                     o_acc_xd,
  input  logic                     i_acc_busy,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);
  rocc_cmd_queue_if #(.W($bits(rocc_cmd_t)), .DEPTH(DEPTH)) u_fif ();

  logic      w_enq, w_match;
  logic      r_drop;
  rocc_cmd_t w_wcmd, w_rcmd;

  // Ready depends only on registered count, never on i_acc_ready.
  assign o_cmd_ready = !u_fif.full;
  assign w_enq       = i_cmd_valid && o_cmd_ready;
  assign w_match     = (i_cmd_bits_inst_opcode == OPCODE);

  always_comb begin
    w_wcmd       = '0;
    w_wcmd.funct = i_cmd_bits_inst_funct;
    w_wcmd.rs1   = i_cmd_bits_inst_xs1 ? ROCC_XLEN'(i_cmd_bits_rs1) : '0;
    w_wcmd.rs2   = i_cmd_bits_inst_xs2 ? ROCC_XLEN'(i_cmd_bits_rs2) : '0;
    w_wcmd.rd    = i_cmd_bits_inst_rd;
    w_wcmd.xd    = i_cmd_bits_inst_xd;
  end

  assign u_fif.push  = w_enq && w_match;
  assign u_fif.wdata = w_wcmd;
  assign u_fif.pop   = i_acc_ready;  // the FIFO ignores a pop while empty
  assign w_rcmd      = u_fif.rdata;

  rocc_sync_fifo #(.W($bits(rocc_cmd_t)), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .f     (u_fif.slave)
  );

  always_ff @(posedge clock) begin
    if (reset) r_drop <= 1'b0;
    else       r_drop <= w_enq && !w_match;
  end

  // The head is zeroed while empty, so stale storage never leaks out.
  assign o_acc_valid = !u_fif.empty;
  assign o_acc_funct = o_acc_valid ? w_rcmd.funct : '0;
  assign o_acc_rs1   = o_acc_valid ? WIDTH'(w_rcmd.rs1) : '0;
  assign o_acc_rs2   = o_acc_valid ? WIDTH'(w_rcmd.rs2) : '0;
  assign o_acc_rd    = o_acc_valid ? w_rcmd.rd : '0;
  assign o_acc_xd    = o_acc_valid && w_rcmd.xd;

  assign o_busy  = o_acc_valid || i_acc_busy;
  assign o_count = u_fif.count;
  assign o_drop  = r_drop;
endmodule

// File: tb/tb_rocc_cmd_queue.sv
// tb_rocc_cmd_queue -- directed self-checking bench for rocc_cmd_queue.
// Inputs change 1 time unit after the rising edge; outputs are checked there,
// well away from the next edge.
module tb_rocc_cmd_queue;
  import rocc_pkg::*;

  localparam int W = 64;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready;
  logic [6:0]   opcode, funct;
  logic [W-1:0] rs1, rs2;
  logic         xs1, xs2, xd;
  logic [4:0]   rd;
  logic         acc_valid, acc_ready;
  logic [6:0]   acc_funct;
  logic [W-1:0] acc_rs1, acc_rs2;
  logic [4:0]   acc_rd;
  logic         acc_xd, acc_busy, busy, drop;
  logic [2:0]   count;

  int n_run = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  rocc_cmd_queue #(.WIDTH(W), .DEPTH(D), .OPCODE(CUSTOM0)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .i_cmd_valid            (cmd_valid),
    .o_cmd_ready            (cmd_ready),
    .i_cmd_bits_inst_opcode (opcode),
    .i_cmd_bits_inst_funct  (funct),
    .i_cmd_bits_rs1         (rs1),
    .i_cmd_bits_inst_xs1    (xs1),
    .i_cmd_bits_rs2         (rs2),
    .i_cmd_bits_inst_xs2    (xs2),
    .i_cmd_bits_inst_rd     (rd),
    .i_cmd_bits_inst_xd     (xd),
    .o_acc_valid            (acc_valid),
    .i_acc_ready            (acc_ready),
    .o_acc_funct            (acc_funct),
    .o_acc_rs1              (acc_rs1),
    .o_acc_rs2              (acc_rs2),
    .o_acc_rd               (acc_rd),
    .o_acc_xd               (acc_xd),
    .i_acc_busy             (acc_busy),
    .o_busy                 (busy),
    .o_count                (count),
    .o_drop                 (drop)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cmd(input logic [6:0] op, input logic [6:0] fn, input logic [W-1:0] a,
                     input logic xa, input logic [W-1:0] b, input logic xb,
                     input logic [4:0] d, input logic x);
    cmd_valid = 1'b1; opcode = op; funct = fn;
    rs1 = a; xs1 = xa; rs2 = b; xs2 = xb; rd = d; xd = x;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; acc_ready = 1'b0; acc_busy = 1'b0;
    opcode = '0; funct = '0; rs1 = '0; rs2 = '0; xs1 = 1'b0; xs2 = 1'b0; rd = '0; xd = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk("rst_ready", cmd_ready, 1);
    chk("rst_valid", acc_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_rs1",   acc_rs1, 0);
    chk("rst_drop",  drop, 0);

    // single command, no fall-through
    acc_ready = 1'b1;
    cmd(CUSTOM0, 7'd1, 64'd5, 1, 64'd7, 1, 5'd3, 1);
    chk("single_nofall", acc_valid, 0);
    tick();
    cmd_valid = 1'b0;
    chk("single_valid", acc_valid, 1);
    chk("single_funct", acc_funct, 1);
    chk("single_rs1",   acc_rs1, 5);
    chk("single_rs2",   acc_rs2, 7);
    chk("single_rd",    acc_rd, 3);
    chk("single_xd",    acc_xd, 1);
    chk("single_cnt1",  count, 1);
    chk("single_busy",  busy, 1);
    tick();
    chk("single_cnt0",  count, 0);
    chk("single_empty", acc_valid, 0);
    chk("single_zero",  acc_rd, 0);

    // empty queue ignores acc_ready
    tick();
    chk("empty_pop", count, 0);

    // fill: 5 offered, 4 taken
    acc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd(CUSTOM0, 7'(i), 64'(10 + i), 1, 64'd0, 1, 5'(i), 0);
      tick();
    end
    chk("fill_count", count, 4);
    chk("fill_ready", cmd_ready, 0);
    chk("fill_head",  acc_rs1, 10);
    // enqueue stays blocked while full even with a same-cycle dequeue
    cmd(CUSTOM0, 7'd4, 64'd14, 1, 64'd0, 1, 5'd4, 0);
    acc_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("full_blocked", count, 3);
    chk("full_ready",   cmd_ready, 1);
    for (int i = 1; i < 4; i++) begin
      chk("fill_order", acc_rs1, 64'(10 + i));
      tick();
    end
    chk("fill_drained", count, 0);

    // non-matching opcode is dropped
    cmd(CUSTOM1, 7'd2, 64'd1, 1, 64'd1, 1, 5'd1, 1);
    chk("drop_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("drop_pulse", drop, 1);
    chk("drop_valid", acc_valid, 0);
    chk("drop_count", count, 0);
    tick();
    chk("drop_end", drop, 0);

    // operand masking
    acc_ready = 1'b0;
    cmd(CUSTOM0, 7'd3, 64'hFFFF, 0, 64'd9, 1, 5'd2, 0);
    tick();
    cmd_valid = 1'b0;
    chk("mask_rs1", acc_rs1, 0);
    chk("mask_rs2", acc_rs2, 9);
    acc_ready = 1'b1;
    tick();
    chk("mask_drain", count, 0);

    // wrap with simultaneous enqueue and dequeue at count 2
    acc_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cmd(CUSTOM0, 7'd0, 64'(100 + i), 1, 64'd0, 1, 5'd0, 0);
      tick();
    end
    chk("wrap_pre", count, 2);
    acc_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cmd(CUSTOM0, 7'd0, 64'(102 + k), 1, 64'd0, 1, 5'd0, 0);
      chk("wrap_head", acc_rs1, 64'(100 + k));
      tick();
      chk("wrap_cnt", count, 2);
    end
    cmd_valid = 1'b0;
    chk("wrap_t0", acc_rs1, 108);
    tick();
    chk("wrap_t1", acc_rs1, 109);
    tick();
    chk("wrap_done", count, 0);

    // reset mid-run discards entries and a same-cycle enqueue
    acc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd(CUSTOM0, 7'd0, 64'(200 + i), 1, 64'd0, 1, 5'd0, 0);
      tick();
    end
    chk("mid_cnt3", count, 3);
    acc_busy = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmd_valid = 1'b0;
    chk("mid_count", count, 0);
    chk("mid_valid", acc_valid, 0);
    chk("mid_busy",  busy, 1);
    chk("mid_ready", cmd_ready, 1);
    acc_busy = 1'b0;
    #1;
    chk("mid_idle", busy, 0);
    // queue usable again from the reset pointers
    cmd(CUSTOM0, 7'd5, 64'd42, 1, 64'd0, 0, 5'd7, 1);
    tick();
    cmd_valid = 1'b0;
    chk("post_rs1", acc_rs1, 42);
    chk("post_cnt", count, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
